// File: rtl/controle_varredura_display.sv
// Scan controller for a multiplexed 7-segment display: parity-checked scrolling
// character buffer, time-multiplexed onto one shared character decoder.
module controle_varredura_display #(
   parameter int unsigned NUM_DIG      = 4,
   parameter int unsigned T_DIGITO     = 1000,
   parameter int unsigned T_GUARDA     = 2,
   parameter bit          PARIDADE_PAR = 1'b1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valido,
   output logic               in_pronto,
   input  logic [5:0]         in_dado,
   input  logic               limpar,
   output logic [4:0]         char_out,
   output logic               validade_out,
   output logic [NUM_DIG-1:0] digito_en,
   output logic               cheio
);

   localparam int unsigned IDX_W   = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;
   localparam int unsigned CNT_W   = $clog2(NUM_DIG + 1);
   localparam int unsigned T_MAX   = (T_DIGITO > T_GUARDA) ? T_DIGITO : T_GUARDA;
   localparam int unsigned TMR_W   = (T_MAX > 1) ? $clog2(T_MAX) : 1;
   localparam logic [4:0]  CHAR_BRANCO = 5'b11111;

   // Elaboration-time parameter range checks
   generate
      if (NUM_DIG < 2 || NUM_DIG > 8) begin : g_err_num_dig
         $error("NUM_DIG must be in 2..8");
      end
      if (T_DIGITO < 1) begin : g_err_t_digito
         $error("T_DIGITO must be >= 1");
      end
      if (T_GUARDA < 1) begin : g_err_t_guarda
         $error("T_GUARDA must be >= 1");
      end
   endgenerate

   typedef struct packed {
      logic       ocupado;
      logic       ok;
      logic [4:0] codigo;
   } entrada_t;

   typedef enum logic {
      APAGA = 1'b0,
      ATIVO = 1'b1
   } estado_t;

   entrada_t           mem_q [NUM_DIG];
   entrada_t           mem_d [NUM_DIG];
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               cheio_q, cheio_d;
   logic               pronto_q;

   estado_t            estado_q, estado_d;
   logic [TMR_W-1:0]   timer_q, timer_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [4:0]         char_q, char_d;
   logic               val_q, val_d;
   logic [NUM_DIG-1:0] en_q, en_d;

   logic               aceita;
   logic               paridade_ok;

   // Handshake: ready once out of reset, dropped combinationally by a clear
   assign in_pronto   = pronto_q & ~limpar;
   assign aceita      = in_valido & in_pronto;
   assign paridade_ok = PARIDADE_PAR ? ~(^in_dado) : (^in_dado);

   // Buffer write/clear: new word enters at entry 0, oldest falls off the top
   always_comb begin
      for (int k = 0; k < int'(NUM_DIG); k++) begin
         mem_d[k] = mem_q[k];
      end
      cnt_d = cnt_q;
      if (limpar) begin
         for (int k = 0; k < int'(NUM_DIG); k++) begin
            mem_d[k] = '0;
         end
         cnt_d = '0;
      end else if (aceita) begin
         for (int k = 1; k < int'(NUM_DIG); k++) begin
            mem_d[k] = mem_q[k-1];
         end
         mem_d[0] = '{ocupado: 1'b1, ok: paridade_ok, codigo: in_dado[4:0]};
         if (cnt_q != CNT_W'(NUM_DIG)) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
      cheio_d = (cnt_d == CNT_W'(NUM_DIG));
   end

   // Scan FSM: blank guard, then one digit lit; char/validity load on entry to ATIVO
   always_comb begin
      estado_d = estado_q;
      timer_d  = timer_q;
      idx_d    = idx_q;
      char_d   = char_q;
      val_d    = val_q;
      en_d     = en_q;
      unique case (estado_q)
         APAGA: begin
            if (timer_q == TMR_W'(T_GUARDA - 1)) begin
               estado_d = ATIVO;
               timer_d  = '0;
               en_d     = NUM_DIG'(1) << idx_q;
               if (mem_q[idx_q].ocupado) begin
                  char_d = mem_q[idx_q].codigo;
                  val_d  = mem_q[idx_q].ok;
               end else begin
                  char_d = CHAR_BRANCO;
                  val_d  = 1'b1;
               end
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end
         ATIVO: begin
            if (timer_q == TMR_W'(T_DIGITO - 1)) begin
               estado_d = APAGA;
               timer_d  = '0;
               en_d     = '0;
               idx_d    = (idx_q == IDX_W'(NUM_DIG - 1)) ? '0 : idx_q + IDX_W'(1);
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end
         default: begin
            estado_d = APAGA;
            timer_d  = '0;
            en_d     = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < int'(NUM_DIG); k++) begin
            mem_q[k] <= '0;
         end
         cnt_q    <= '0;
         cheio_q  <= 1'b0;
         pronto_q <= 1'b0;
         estado_q <= APAGA;
         timer_q  <= '0;
         idx_q    <= '0;
         char_q   <= CHAR_BRANCO;
         val_q    <= 1'b1;
         en_q     <= '0;
      end else begin
         for (int k = 0; k < int'(NUM_DIG); k++) begin
            mem_q[k] <= mem_d[k];
         end
         cnt_q    <= cnt_d;
         cheio_q  <= cheio_d;
         pronto_q <= 1'b1;
         estado_q <= estado_d;
         timer_q  <= timer_d;
         idx_q    <= idx_d;
         char_q   <= char_d;
         val_q    <= val_d;
         en_q     <= en_d;
      end
   end

   assign char_out     = char_q;
   assign validade_out = val_q;
   assign digito_en    = en_q;
   assign cheio        = cheio_q;

endmodule

// File: tb/tb_controle_varredura_display.sv
// Directed bench for controle_varredura_display: per-cycle stimulus table and
// per-cycle expected-output table with hand-computed values (4 digits, 4+2 cycle slots).
module tb_controle_varredura_display;

   localparam int unsigned NUM_DIG = 4;
   localparam int          N_CYC   = 100;
   localparam int          T_ESPERA = 40;

   logic               clk;
   logic               reset;
   logic               in_valido;
   logic               in_pronto;
   logic [5:0]         in_dado;
   logic               limpar;
   logic [4:0]         char_out;
   logic               validade_out;
   logic [NUM_DIG-1:0] digito_en;
   logic               cheio;

   controle_varredura_display #(
      .NUM_DIG     (NUM_DIG),
      .T_DIGITO    (4),
      .T_GUARDA    (2),
      .PARIDADE_PAR(1'b1)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .in_valido   (in_valido),
      .in_pronto   (in_pronto),
      .in_dado     (in_dado),
      .limpar      (limpar),
      .char_out    (char_out),
      .validade_out(validade_out),
      .digito_en   (digito_en),
      .cheio       (cheio)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int         cyc;
      logic       rst;
      logic       vld;
      logic [5:0] dado;
      logic       lim;
   } estim_t;

   typedef struct {
      int         cyc;
      string      nome;
      logic [3:0] en;
      logic [4:0] chr;
      logic       val;
      logic       ch;
      logic       chk_pr;
      logic       pr;
   } verif_t;

   estim_t est[$];
   verif_t chk[$];
   int     erros;
   int     total;
   int     espera;

   initial begin
      erros     = 0;
      total     = 0;
      espera    = 0;
      reset     = 1'b1;
      in_valido = 1'b0;
      in_dado   = '0;
      limpar    = 1'b0;

      // Slot starts: idx0 at 5+24n, idx1 at 11+24n, idx2 at 17+24n, idx3 at 23+24n
      est.push_back('{6,  1'b0, 1'b1, 6'b100001, 1'b0}); // code 1, parity ok
      est.push_back('{12, 1'b0, 1'b1, 6'b000010, 1'b0}); // code 2, bad parity
      est.push_back('{28, 1'b0, 1'b1, 6'b000011, 1'b0}); // code 3 on idx0 load edge
      est.push_back('{30, 1'b0, 1'b1, 6'b100100, 1'b0}); // code 4 -> full
      est.push_back('{31, 1'b0, 1'b1, 6'b000101, 1'b0}); // code 5 -> code 1 dropped
      est.push_back('{57, 1'b0, 1'b1, 6'b100110, 1'b1}); // clear with valid word
      est.push_back('{81, 1'b0, 1'b1, 6'b000110, 1'b0}); // code 6, wiped by reset
      est.push_back('{90, 1'b1, 1'b0, 6'b000000, 1'b0}); // reset mid idx2 slot

      chk.push_back('{1,  "rst_state",      4'b0000, 5'b11111, 1'b1, 1'b0, 1'b1, 1'b0});
      chk.push_back('{3,  "post_rst",       4'b0000, 5'b11111, 1'b1, 1'b0, 1'b0, 1'b0});
      chk.push_back('{4,  "guard_1",        4'b0000, 5'b11111, 1'b1, 1'b0, 1'b1, 1'b1});
      chk.push_back('{5,  "slot0_first",    4'b0001, 5'b11111, 1'b1, 1'b0, 1'b1, 1'b1});
      chk.push_back('{7,  "slot0_noglitch", 4'b0001, 5'b11111, 1'b1, 1'b0, 1'b0, 1'b0});
      chk.push_back('{8,  "slot0_last",     4'b0001, 5'b11111, 1'b1, 1'b0, 1'b0, 1'b0});
      chk.push_back('{9,  "guard_a",        4'b0000, 5'b11111, 1'b1, 1'b0, 1'b0, 1'b0});
      chk.push_back('{11, "slot1",          4'b0010, 5'b11111, 1'b1, 1'b0, 1'b0, 1'b0});
      chk.push_back('{13, "slot1_midwrite", 4'b0010, 5'b11111, 1'b1, 1'b0, 1'b0, 1'b0});
      chk.push_back('{17, "slot2",          4'b0100, 5'b11111, 1'b1, 1'b0, 1'b0, 1'b0});
      chk.push_back('{23, "slot3",          4'b1000, 5'b11111, 1'b1, 1'b0, 1'b0, 1'b0});
      chk.push_back('{29, "load_prewrite",  4'b0001, 5'b00010, 1'b0, 1'b0, 1'b1, 1'b1});
      chk.push_back('{31, "cheio_4th",      4'b0001, 5'b00010, 1'b0, 1'b1, 1'b1, 1'b1});
      chk.push_back('{32, "cheio_sat",      4'b0001, 5'b00010, 1'b0, 1'b1, 1'b0, 1'b0});
      chk.push_back('{35, "scroll_e1",      4'b0010, 5'b00100, 1'b1, 1'b1, 1'b0, 1'b0});
      chk.push_back('{41, "scroll_e2",      4'b0100, 5'b00011, 1'b1, 1'b1, 1'b0, 1'b0});
      chk.push_back('{47, "scroll_e3",      4'b1000, 5'b00010, 1'b0, 1'b1, 1'b0, 1'b0});
      chk.push_back('{53, "scroll_e0",      4'b0001, 5'b00101, 1'b1, 1'b1, 1'b0, 1'b0});
      chk.push_back('{57, "clr_pronto",     4'b0000, 5'b00101, 1'b1, 1'b1, 1'b1, 1'b0});
      chk.push_back('{58, "clr_cheio",      4'b0000, 5'b00101, 1'b1, 1'b0, 1'b1, 1'b1});
      chk.push_back('{59, "clr_blank_e1",   4'b0010, 5'b11111, 1'b1, 1'b0, 1'b0, 1'b0});
      chk.push_back('{77, "clr_no_write",   4'b0001, 5'b11111, 1'b1, 1'b0, 1'b0, 1'b0});
      chk.push_back('{90, "pre_rst",        4'b0100, 5'b11111, 1'b1, 1'b0, 1'b1, 1'b1});
      chk.push_back('{91, "rst_mid",        4'b0000, 5'b11111, 1'b1, 1'b0, 1'b1, 1'b0});
      chk.push_back('{92, "rst_guard",      4'b0000, 5'b11111, 1'b1, 1'b0, 1'b1, 1'b1});
      chk.push_back('{93, "rst_restart",    4'b0001, 5'b11111, 1'b1, 1'b0, 1'b0, 1'b0});
      chk.push_back('{97, "rst_guard_a",    4'b0000, 5'b11111, 1'b1, 1'b0, 1'b0, 1'b0});

      for (int c = 0; c < N_CYC; c++) begin
         @(negedge clk);
         reset     = (c < 3);
         in_valido = 1'b0;
         in_dado   = '0;
         limpar    = 1'b0;
         foreach (est[i]) begin
            if (est[i].cyc == c) begin
               reset     = reset | est[i].rst;
               in_valido = est[i].vld;
               in_dado   = est[i].dado;
               limpar    = est[i].lim;
            end
         end
         #1;
         foreach (chk[i]) begin
            if (chk[i].cyc == c) begin
               total++;
               if (digito_en !== chk[i].en || char_out !== chk[i].chr ||
                   validade_out !== chk[i].val || cheio !== chk[i].ch ||
                   (chk[i].chk_pr && in_pronto !== chk[i].pr)) begin
                  erros++;
                  $display("FAIL %s (cycle %0d): got en=%b char=%b val=%b cheio=%b pronto=%b, want en=%b char=%b val=%b cheio=%b pronto=%s",
                           chk[i].nome, c, digito_en, char_out, validade_out, cheio, in_pronto,
                           chk[i].en, chk[i].chr, chk[i].val, chk[i].ch,
                           chk[i].chk_pr ? (chk[i].pr ? "1" : "0") : "-");
               end
            end
         end
      end

      // Final reset: all outputs must return to reset values
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      #1;
      total++;
      if (digito_en !== 4'b0000 || char_out !== 5'b11111 || validade_out !== 1'b1 ||
          cheio !== 1'b0 || in_pronto !== 1'b0) begin
         erros++;
         $display("FAIL reset_final: got en=%b char=%b val=%b cheio=%b pronto=%b",
                  digito_en, char_out, validade_out, cheio, in_pronto);
      end

      // Scan must reach idx 0 within a bounded wait after reset release
      @(negedge clk);
      reset = 1'b0;
      #1;
      while (digito_en !== 4'b0001 && espera < T_ESPERA) begin
         @(negedge clk);
         #1;
         espera++;
      end
      total++;
      if (digito_en !== 4'b0001) begin
         erros++;
         $display("FAIL wait_expired: digito_en=%b after %0d cycles", digito_en, espera);
      end

      $display("Result: errors=%0d of %0d checks", erros, total);
      $finish;
   end

endmodule
